// File: rtl/fpmac_pkg.sv
// fpmac_pkg: shared constants, feed-controller states and lane slicing for the FP8 MAC array.
package fpmac_pkg;
    localparam int N_DEF = 3;
    localparam int W_DEF = 8;

    typedef enum logic [2:0] {IDLE, CLEAR, FEED, DRAIN, DONE} state_t;

    function automatic int lane_lsb(input int lane, input int w);
        return lane * w;
    endfunction
endpackage

// File: rtl/operand_bank.sv
// operand_bank: N x N operand register file with N diagonally skewed read lanes.
module operand_bank
    import fpmac_pkg::*;
#(
    parameter int N        = N_DEF,
    parameter int W        = W_DEF,
    parameter int IW       = $clog2(N),
    parameter int CW       = $clog2(2 * N),
    parameter bit COL_SKEW = 1'b0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            we,
    input  logic [IW-1:0]   row,
    input  logic [IW-1:0]   col,
    input  logic [W-1:0]    data,
    input  logic [CW-1:0]   t,
    output logic [N*W-1:0]  lanes
);
    logic [W-1:0] mem [N][N];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < N; i++)
                for (int j = 0; j < N; j++)
                    mem[i][j] <= '0;
        end else if (we) begin
            mem[row][col] <= data;
        end
    end

    // lane l sees element t-l of its row (X) or column (Y); outside the window it carries the zero bubble
    for (genvar l = 0; l < N; l++) begin : g_lane
        logic [CW-1:0] d;
        logic [IW-1:0] k;
        assign d = t - CW'(l);
        assign k = IW'(d);
        assign lanes[lane_lsb(l, W) +: W] = (t >= CW'(l) && d < CW'(N)) ?
                                            (COL_SKEW ? mem[k][l] : mem[l][k]) : '0;
    end
endmodule

// File: rtl/systolic_feed_ctrl.sv
// systolic_feed_ctrl: sequences one N x N multiply by feeding skewed X/Y wavefronts into the MAC array.
module systolic_feed_ctrl
    import fpmac_pkg::*;
#(
    parameter int N  = N_DEF,
    parameter int W  = W_DEF,
    parameter int IW = $clog2(N)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            wr_en,
    input  logic            wr_sel,
    input  logic [IW-1:0]   wr_row,
    input  logic [IW-1:0]   wr_col,
    input  logic [W-1:0]    wr_data,
    input  logic            start,
    output logic            busy,
    output logic            done,
    output logic            array_clr,
    output logic [N*W-1:0]  west_out,
    output logic [N*W-1:0]  north_out
);
    localparam int CW = $clog2(2 * N);
    localparam int RW = IW + 1;

    state_t          state, nstate;
    logic [CW-1:0]   cnt, ncnt;
    logic            accept, wr_ok;
    logic [N*W-1:0]  west_rd, north_rd;

    // the done cycle still reads as busy, so idle means both the state and the busy flag agree
    assign accept = (state == IDLE) && !busy;
    assign wr_ok  = wr_en && accept && ({1'b0, wr_row} < RW'(N)) && ({1'b0, wr_col} < RW'(N));

    operand_bank #(.N(N), .W(W), .IW(IW), .CW(CW), .COL_SKEW(1'b0)) u_x (
        .clk(clk), .reset(reset), .we(wr_ok && !wr_sel), .row(wr_row), .col(wr_col),
        .data(wr_data), .t(cnt), .lanes(west_rd)
    );

    operand_bank #(.N(N), .W(W), .IW(IW), .CW(CW), .COL_SKEW(1'b1)) u_y (
        .clk(clk), .reset(reset), .we(wr_ok && wr_sel), .row(wr_row), .col(wr_col),
        .data(wr_data), .t(cnt), .lanes(north_rd)
    );

    always_comb begin
        nstate = state;
        unique case (state)
            IDLE:    nstate = (start && accept) ? CLEAR : IDLE;
            CLEAR:   nstate = FEED;
            FEED:    nstate = (cnt == CW'(2 * N - 2)) ? DRAIN : FEED;
            DRAIN:   nstate = (cnt == CW'(N - 1)) ? DONE : DRAIN;
            DONE:    nstate = IDLE;
            default: nstate = IDLE;
        endcase
        ncnt = (nstate == state && state != IDLE) ? cnt + CW'(1) : '0;
    end

    // outputs are decoded from the registered state one cycle later, giving a start-to-done latency of 3N+1
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            array_clr <= 1'b0;
            west_out  <= '0;
            north_out <= '0;
        end else begin
            state     <= nstate;
            cnt       <= ncnt;
            busy      <= state != IDLE;
            done      <= state == DONE;
            array_clr <= state == CLEAR;
            west_out  <= (state == FEED) ? west_rd : '0;
            north_out <= (state == FEED) ? north_rd : '0;
        end
    end
endmodule

// File: tb/tb_systolic_feed_ctrl.sv
// tb_systolic_feed_ctrl: scoreboard bench for the skewed operand feed, timing and busy protections.
module tb_systolic_feed_ctrl;
    localparam int N  = 3;
    localparam int W  = 8;
    localparam int IW = $clog2(N);

    logic            clk = 1'b0;
    logic            reset, wr_en, wr_sel, start;
    logic [IW-1:0]   wr_row, wr_col;
    logic [W-1:0]    wr_data;
    logic            busy, done, array_clr;
    logic [N*W-1:0]  west_out, north_out;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] mx [N][N];
    logic [W-1:0] my [N][N];

    typedef struct packed {
        logic           clr;
        logic           busy;
        logic           done;
        logic [N*W-1:0] west;
        logic [N*W-1:0] north;
    } exp_t;

    exp_t sb[$];

    systolic_feed_ctrl #(.N(N), .W(W), .IW(IW)) dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_sel(wr_sel), .wr_row(wr_row),
        .wr_col(wr_col), .wr_data(wr_data), .start(start), .busy(busy), .done(done),
        .array_clr(array_clr), .west_out(west_out), .north_out(north_out)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic write(input logic sel, input int r, input int c, input logic [W-1:0] d);
        wr_en   = 1'b1;
        wr_sel  = sel;
        wr_row  = IW'(r);
        wr_col  = IW'(c);
        wr_data = d;
        tick;
        wr_en = 1'b0;
        if (r < N && c < N) begin
            if (sel) my[r][c] = d;
            else     mx[r][c] = d;
        end
    endtask

    task automatic push_run;
        exp_t e;
        int t;
        for (int c = 1; c <= 3 * N + 3; c++) begin
            e      = '0;
            e.busy = (c <= 3 * N + 1);
            e.clr  = (c == 1);
            e.done = (c == 3 * N + 1);
            if (c >= 2 && c <= 2 * N) begin
                t = c - 2;
                for (int l = 0; l < N; l++) begin
                    if (t - l >= 0 && t - l < N) begin
                        e.west[l*W +: W]  = mx[l][t-l];
                        e.north[l*W +: W] = my[t-l][l];
                    end
                end
            end
            sb.push_back(e);
        end
    endtask

    task automatic start_run;
        start = 1'b1;
        tick;
        start = 1'b0;
        push_run;
    endtask

    task automatic check_run(input string name, input int mode, input int poke, input int stop);
        exp_t e;
        for (int c = 1; c <= 3 * N + 3; c++) begin
            if (c == poke) begin
                wr_en = 1'b1; wr_sel = 1'b0; wr_row = '0; wr_col = '0; wr_data = 8'hFF; start = 1'b1;
            end
            tick;
            wr_en = 1'b0;
            start = 1'b0;
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL %s cyc %0d: scoreboard empty", name, c);
                return;
            end
            e = sb.pop_front();
            if ({array_clr, busy, done, west_out, north_out} !== e) begin
                errors++;
                $display("FAIL %s cyc %0d: got clr=%b busy=%b done=%b west=%h north=%h, exp clr=%b busy=%b done=%b west=%h north=%h",
                         name, c, array_clr, busy, done, west_out, north_out, e.clr, e.busy, e.done, e.west, e.north);
            end
            if (mode == 1 && (c == 2 || c == 3 || c == 6)) begin
                checks++;
                if (c == 2 && (west_out !== 24'h000010 || north_out !== 24'h000020) ||
                    c == 3 && (west_out !== 24'h001311 || north_out !== 24'h002123) ||
                    c == 6 && (west_out !== 24'h180000 || north_out !== 24'h280000)) begin
                    errors++;
                    $display("FAIL %s_const cyc %0d: got west=%h north=%h", name, c, west_out, north_out);
                end
            end
            if (mode == 2 && c == 2) begin
                checks++;
                if (west_out[W-1:0] !== 8'h3C) begin
                    errors++;
                    $display("FAIL %s_lane0 cyc 2: got %h exp 3c", name, west_out[W-1:0]);
                end
            end
            if (c == stop) return;
        end
    endtask

    task automatic idle_check(input string name, input int n);
        for (int c = 0; c < n; c++) begin
            tick;
            checks++;
            if ({array_clr, busy, done, west_out, north_out} !== '0) begin
                errors++;
                $display("FAIL %s cyc %0d: got clr=%b busy=%b done=%b west=%h north=%h, exp all 0",
                         name, c, array_clr, busy, done, west_out, north_out);
            end
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        tick;
        tick;
        checks++;
        if ({array_clr, busy, done, west_out, north_out} !== '0) begin
            errors++;
            $display("FAIL reset_state: got clr=%b busy=%b done=%b west=%h north=%h, exp all 0",
                     array_clr, busy, done, west_out, north_out);
        end
        reset = 1'b0;
        idle_check("reset_idle", 20);
    endtask

    task automatic test_skew;
        for (int i = 0; i < N; i++)
            for (int k = 0; k < N; k++) begin
                write(1'b0, i, k, W'(8'h10 + 3 * i + k));
                write(1'b1, i, k, W'(8'h20 + 3 * i + k));
            end
        start_run;
        check_run("skew", 1, 0, 0);
    endtask

    task automatic test_repeat;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                write(1'b0, i, j, (i == j) ? 8'h38 : 8'h00);
                write(1'b1, i, j, W'(8'h41 + 5 * i + 2 * j));
            end
        start_run;
        check_run("repeat1", 0, 0, 0);
        start_run;
        check_run("repeat2", 0, 0, 0);
    endtask

    task automatic test_busy_protect;
        start_run;
        check_run("busy_poke", 0, 3, 0);
        start_run;
        check_run("busy_after", 0, 0, 0);
    endtask

    task automatic test_same_cycle;
        write(1'b0, 3, 0, 8'hAA);
        write(1'b1, 0, 3, 8'hBB);
        wr_en = 1'b1; wr_sel = 1'b0; wr_row = '0; wr_col = '0; wr_data = 8'h3C; start = 1'b1;
        tick;
        wr_en = 1'b0;
        start = 1'b0;
        mx[0][0] = 8'h3C;
        push_run;
        check_run("same_cycle", 2, 0, 0);
    endtask

    task automatic test_reset_mid;
        start_run;
        check_run("mid", 0, 0, 5);
        sb.delete();
        reset = 1'b1;
        tick;
        reset = 1'b0;
        checks++;
        if ({array_clr, busy, done, west_out, north_out} !== '0) begin
            errors++;
            $display("FAIL mid_reset: got clr=%b busy=%b done=%b west=%h north=%h, exp all 0",
                     array_clr, busy, done, west_out, north_out);
        end
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                mx[i][j] = '0;
                my[i][j] = '0;
            end
        idle_check("mid_quiet", 12);
        write(1'b0, 1, 2, 8'h5A);
        write(1'b1, 2, 1, 8'hA5);
        write(1'b0, 2, 0, 8'h77);
        start_run;
        check_run("fresh", 0, 0, 0);
    endtask

    initial begin
        reset = 1'b1; wr_en = 1'b0; wr_sel = 1'b0; start = 1'b0;
        wr_row = '0; wr_col = '0; wr_data = '0;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                mx[i][j] = '0;
                my[i][j] = '0;
            end
        test_reset;
        test_skew;
        test_repeat;
        test_busy_protect;
        test_same_cycle;
        test_reset_mid;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
